// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: round-robin between the ALU and load writeback ports,
// with a clear sweep of every register after reset or on an init_start request.
module regfile_wb_arb #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_gnt,
  input  logic              mem_req,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_gnt,
  input  logic              init_start,
  output logic              busy,
  output logic              wen,
  output logic [SEL_W-1:0]  selRd,
  output logic [DATA_W-1:0] rd
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_idx;
  logic              r_last_mem;
  logic              w_arb_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_idx == {SEL_W{1'b1}}) w_state_nxt = ST_RUN;
      ST_RUN:  if (init_start)             w_state_nxt = ST_INIT;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Grants are suppressed on the init_start cycle so nothing is accepted as the sweep begins.
  always_comb begin
    busy     = (r_state == ST_INIT);
    w_arb_en = (r_state == ST_RUN) && !init_start;
    alu_gnt  = w_arb_en && alu_req && (!mem_req ||  r_last_mem);
    mem_gnt  = w_arb_en && mem_req && (!alu_req || !r_last_mem);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_last_mem <= 1'b1;
      wen        <= 1'b0;
      selRd      <= '0;
      rd         <= '0;
    end else begin
      wen <= 1'b0;
      if (r_state == ST_INIT) begin
        // idx wraps to 0 on the last register, which is exactly the RUN entry value.
        wen   <= 1'b1;
        selRd <= r_idx;
        rd    <= '0;
        r_idx <= r_idx + 1'b1;
      end else if (init_start) begin
        r_idx <= '0;
      end else if (alu_gnt) begin
        wen        <= 1'b1;
        selRd      <= alu_sel;
        rd         <= alu_data;
        r_last_mem <= 1'b0;
      end else if (mem_gnt) begin
        wen        <= 1'b1;
        selRd      <= mem_sel;
        rd         <= mem_data;
        r_last_mem <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: expected writes are queued as stimulus is driven
// and retired in order by a monitor watching wen/selRd/rd.
module tb_regfile_wb_arb;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;
  localparam int NREG   = 1 << SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_req, mem_req, init_start;
  logic [SEL_W-1:0]  alu_sel, mem_sel;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_gnt, mem_gnt, busy, wen;
  logic [SEL_W-1:0]  selRd;
  logic [DATA_W-1:0] rd;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  regfile_wb_arb #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_sel(alu_sel), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .init_start(init_start), .busy(busy), .wen(wen), .selRd(selRd), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int sel, input int data);
    wr_t e;
    e.sel  = SEL_W'(sel);
    e.data = DATA_W'(data);
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NREG; i++) push(i, 0);
  endtask

  // Retire one expected write for every cycle the DUT presents wen.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wen === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_write", {16'h0, rd}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("wr_sel",  32'(selRd), 32'(e.sel));
          chk("wr_data", 32'(rd),    32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; init_start = 1'b0;
    alu_req = 1'b1; alu_sel = '0; alu_data = '0;
    mem_req = 1'b1; mem_sel = '0; mem_data = '0;
    tick(); tick();
    chk("rst_wen",   32'(wen),     0);
    chk("rst_sel",   32'(selRd),   0);
    chk("rst_rd",    32'(rd),      0);
    chk("rst_busy",  32'(busy),    1);
    chk("rst_agnt",  32'(alu_gnt), 0);
    chk("rst_mgnt",  32'(mem_gnt), 0);
    alu_req = 1'b0; mem_req = 1'b0;

    // Power-up sweep
    push_sweep();
    rst = 1'b1;
    for (int k = 1; k <= NREG; k++) begin
      tick();
      chk("sweep_busy", 32'(busy), (k < NREG) ? 1 : 0);
    end
    tick();
    chk("post_sweep_wen", 32'(wen), 0);

    // Both requesters held: ALU wins the first tie, then alternation
    alu_req = 1'b1; alu_sel = 4'd1; alu_data = 16'hAAAA;
    mem_req = 1'b1; mem_sel = 4'd2; mem_data = 16'h5555;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_agnt", 32'(alu_gnt), (c % 2 == 0) ? 1 : 0);
      chk("rr_mgnt", 32'(mem_gnt), (c % 2 == 0) ? 0 : 1);
      if (c % 2 == 0) push(1, 16'hAAAA); else push(2, 16'h5555);
      tick();
      chk("rr_wen", 32'(wen), 1);
    end
    alu_req = 1'b0; mem_req = 1'b0;
    tick();
    chk("rr_idle_wen", 32'(wen), 0);

    // Single ALU write, same-cycle grant
    alu_req = 1'b1; alu_sel = 4'd3; alu_data = 16'h1234;
    #1;
    chk("alu_gnt", 32'(alu_gnt), 1);
    chk("alu_mgnt", 32'(mem_gnt), 0);
    push(3, 16'h1234);
    tick();
    alu_req = 1'b0;
    chk("alu_wen", 32'(wen), 1);
    tick();
    chk("alu_idle_wen", 32'(wen), 0);
    chk("alu_hold_rd", 32'(rd), 32'h1234);

    // init_start with a pending load; a second init_start mid-sweep is ignored
    mem_req = 1'b1; mem_sel = 4'd9; mem_data = 16'hBEEF;
    init_start = 1'b1;
    #1;
    chk("init_mgnt", 32'(mem_gnt), 0);
    push_sweep();
    push(9, 16'hBEEF);
    tick();
    chk("init_edge_wen", 32'(wen), 0);
    for (int k = 0; k < NREG; k++) begin
      init_start = (k == 5);
      #1;
      chk("sweep_mgnt", 32'(mem_gnt), 0);
      chk("sweep_busy2", 32'(busy), 1);
      tick();
    end
    init_start = 1'b0;
    #1;
    chk("after_sweep_mgnt", 32'(mem_gnt), 1);
    tick();
    mem_req = 1'b0;
    tick();

    // Reset mid-sweep at idx 7
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 7; i++) push(i, 0);
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b0;
    #1;
    chk("midrst_wen", 32'(wen), 0);
    chk("midrst_busy", 32'(busy), 1);
    tick();
    chk("midrst_wen2", 32'(wen), 0);
    tick();
    push_sweep();
    rst = 1'b1;
    for (int k = 1; k <= NREG; k++) tick();
    chk("resweep_busy", 32'(busy), 0);

    // Same destination from both ports: two writes, ALU first after reset
    alu_req = 1'b1; alu_sel = 4'd5; alu_data = 16'h0001;
    mem_req = 1'b1; mem_sel = 4'd5; mem_data = 16'h0002;
    #1;
    chk("same_agnt", 32'(alu_gnt), 1);
    chk("same_mgnt", 32'(mem_gnt), 0);
    push(5, 16'h0001);
    tick();
    alu_req = 1'b0;
    #1;
    chk("same_mgnt2", 32'(mem_gnt), 1);
    chk("same_agnt2", 32'(alu_gnt), 0);
    push(5, 16'h0002);
    tick();
    mem_req = 1'b0;
    chk("same_final_sel", 32'(selRd), 5);
    chk("same_final_rd",  32'(rd),    32'h0002);
    tick();
    chk("same_idle_wen", 32'(wen), 0);

    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
- REQ-001: Parameter DATA_W, default 16, sets the register data width.
- REQ-002: Parameter SEL_W, default 4, sets the register select width; the block addresses 2^SEL_W registers.
- REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, asynchronous, active-low.
- REQ-005: alu_req  input  1  ALU writeback request.
- REQ-006: alu_sel  input  SEL_W  ALU destination register.
- REQ-007: alu_data  input  DATA_W  ALU write data.
- REQ-008: alu_gnt  output  1  ALU request accepted this cycle.
- REQ-009: mem_req  input  1  load writeback request.
- REQ-010: mem_sel  input  SEL_W  load destination register.
- REQ-011: mem_data  input  DATA_W  load write data.
- REQ-012: mem_gnt  output  1  load request accepted this cycle.
- REQ-013: init_start  input  1  one-cycle pulse requesting a clear sweep of all registers.
- REQ-014: busy  output  1  clear sweep in progress.
- REQ-015: wen  output  1  regfile write enable, registered.
- REQ-016: selRd  output  SEL_W  regfile write select, registered.
- REQ-017: rd  output  DATA_W  regfile write data, registered.

Function
- REQ-018: The controller SHALL be a two-state FSM, INIT and RUN, plus an SEL_W-bit sweep index idx.
- REQ-019: In INIT, each rising edge SHALL register wen=1, selRd=idx, rd=0 and increment idx; on the edge where idx equals 2^SEL_W-1, the state SHALL become RUN and idx SHALL return to 0.
- REQ-020: A sweep SHALL therefore write zero to registers 0..2^SEL_W-1 in ascending order on 2^SEL_W consecutive edges.
- REQ-021: busy SHALL equal (state==INIT), combinationally.
- REQ-022: alu_gnt and mem_gnt SHALL be combinational, SHALL be 0 in INIT, and SHALL never both be 1.
- REQ-023: In RUN, a single requester SHALL be granted in the same cycle it asserts req.
- REQ-024: In RUN with both requests asserted, the grant SHALL go to the requester not granted most recently (round-robin); the last-granted pointer SHALL update only on a grant.
- REQ-025: A request is accepted when req and gnt are both 1 at a rising edge; the requester SHALL hold req, sel and data stable until accepted.
- REQ-026: On the edge accepting a request, wen=1 and selRd/rd SHALL take the accepted sel/data; the write SHALL be presented for exactly one cycle (latency 1, throughput 1 write/cycle).
- REQ-027: On RUN edges with no acceptance, wen SHALL be 0 and selRd/rd SHALL hold their previous values.
- REQ-028: Both requesters targeting the same register SHALL be served as two separate writes in round-robin order; no merging or dropping.
- REQ-029: init_start=1 in RUN SHALL move the state to INIT on the next edge with idx=0; grants SHALL be 0 in that cycle, and no request SHALL be accepted on that edge.
- REQ-030: A write accepted on the edge before init_start is already registered and SHALL complete unchanged.
- REQ-031: init_start in INIT SHALL be ignored; the sweep SHALL continue from the current idx.

Reset
- REQ-032: While rst=0: state=INIT, idx=0, wen=0, selRd=0, rd=0, last-granted pointer=mem (so the ALU wins the first tie), busy=1, and both gnts=0.
- REQ-033: Assertion of rst mid-sweep or mid-RUN SHALL abort immediately; after release, a full sweep SHALL start from register 0 on the first edge.

Verification
- REQ-034: Reset release, no requests -> edges 1..16 show wen=1, selRd=0..15, rd=0; busy falls after edge 16; edge 17 shows wen=0.
- REQ-035: RUN, alu_req with sel=3, data=0x1234 for one cycle -> alu_gnt=1 that cycle; next cycle wen=1, selRd=3, rd=0x1234; then wen=0.
- REQ-036: RUN, both requests held for 4 cycles (alu sel=1/0xAAAA, mem sel=2/0x5555, each dropped after acceptance and re-raised) -> grants alternate ALU, MEM, ALU, MEM; wen=1 on 4 consecutive cycles.
- REQ-037: RUN, init_start pulse while mem_req=1 -> mem_gnt=0 that cycle and during all 16 sweep cycles; mem is granted on the first RUN cycle afterward and its write follows register 15's clear.
- REQ-038: rst=0 asserted at sweep idx=7, held 2 cycles, then released -> wen=0 during reset; the sweep restarts at selRd=0 and performs 16 writes.
- REQ-039: Both requesters target sel=5 (ALU 0x0001, MEM 0x0002) -> two writes to register 5, ALU first after reset; the final value presented is 0x0002.
